// File: rtl/alu_cmd_pkg.sv
// Shared types and widths for the ALU command issue stage.
package alu_cmd_pkg;

    localparam int unsigned DW  = 8;
    localparam int unsigned OPW = 3;

    // One buffered command: operands, opcode and drain request.
    typedef struct packed {
        logic [DW-1:0]  ain;
        logic [DW-1:0]  bin;
        logic [OPW-1:0] opcode;
        logic           barrier;
    } cmd_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } issue_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Small synchronous command FIFO; head is the oldest entry, valid while not empty.
module alu_cmd_fifo
    import alu_cmd_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  cmd_t                       push_data,
    input  logic                       pop,
    output cmd_t                       head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    cmd_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array; no reset needed since occupancy guards every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_issue.sv
// Command issue stage feeding the ALU: buffers commands, issues one per cycle,
// honours stall and inserts drain cycles after barrier commands.
module alu_cmd_issue
    import alu_cmd_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [DW-1:0]              cmd_ain,
    input  logic [DW-1:0]              cmd_bin,
    input  logic [OPW-1:0]             cmd_opcode,
    input  logic                       cmd_barrier,
    input  logic                       stall,
    output logic [DW-1:0]              ain,
    output logic [DW-1:0]              bin,
    output logic [OPW-1:0]             opcode,
    output logic                       issue,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy
);

    localparam int unsigned DCW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    cmd_t           push_data;
    cmd_t           head;
    logic           full;
    logic           empty;
    logic           pop;
    issue_state_t   state;
    logic [DCW-1:0] drain_cnt;

    assign push_data = '{ain: cmd_ain, bin: cmd_bin, opcode: cmd_opcode, barrier: cmd_barrier};

    // Readiness depends only on occupancy, never on a same-cycle pop.
    assign cmd_ready = !full && !rst;
    assign pop       = !empty && !stall && (state == RUN);
    assign busy      = (count != '0) || (state == DRAIN) || issue;

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid && cmd_ready),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Issue FSM, drain counter and registered ALU-facing outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            drain_cnt <= '0;
            ain       <= '0;
            bin       <= '0;
            opcode    <= '0;
            issue     <= 1'b0;
        end else begin
            issue <= pop;
            if (pop) begin
                ain    <= head.ain;
                bin    <= head.bin;
                opcode <= head.opcode;
            end
            case (state)
                RUN: begin
                    if (pop && head.barrier && (DRAIN_CYCLES != 0)) begin
                        state     <= DRAIN;
                        drain_cnt <= DCW'(DRAIN_CYCLES);
                    end
                end
                DRAIN: begin
                    // Counts down regardless of stall; last drain cycle is when it reads 1.
                    drain_cnt <= drain_cnt - DCW'(1);
                    if (drain_cnt == DCW'(1)) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Directed self-checking bench for alu_cmd_issue with an in-order scoreboard.
module tb_alu_cmd_issue;
    import alu_cmd_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic           clk = 1'b0;
    logic           rst;
    logic           cmd_valid;
    logic [DW-1:0]  cmd_ain;
    logic [DW-1:0]  cmd_bin;
    logic [OPW-1:0] cmd_opcode;
    logic           cmd_barrier;
    logic           stall;

    logic           cmd_ready, issue, busy;
    logic [DW-1:0]  ain, bin;
    logic [OPW-1:0] opcode;
    logic [CW-1:0]  count;

    logic           cmd_ready_z, issue_z, busy_z;
    logic [DW-1:0]  ain_z, bin_z;
    logic [OPW-1:0] opcode_z;
    logic [CW-1:0]  count_z;

    int   n_cmp = 0;
    int   n_err = 0;
    cmd_t sb[$];

    always #5 clk = ~clk;

    alu_cmd_issue #(.DEPTH(DEPTH), .DRAIN_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ain(cmd_ain), .cmd_bin(cmd_bin), .cmd_opcode(cmd_opcode),
        .cmd_barrier(cmd_barrier), .stall(stall), .ain(ain), .bin(bin),
        .opcode(opcode), .issue(issue), .count(count), .busy(busy)
    );

    alu_cmd_issue #(.DEPTH(DEPTH), .DRAIN_CYCLES(0)) dut_z (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_z),
        .cmd_ain(cmd_ain), .cmd_bin(cmd_bin), .cmd_opcode(cmd_opcode),
        .cmd_barrier(cmd_barrier), .stall(stall), .ain(ain_z), .bin(bin_z),
        .opcode(opcode_z), .issue(issue_z), .count(count_z), .busy(busy_z)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Present a command and hold it until accepted (bounded); valid stays high.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic bar);
        int   budget = 50;
        logic acc;
        cmd_valid   = 1'b1;
        cmd_ain     = a;
        cmd_bin     = b;
        cmd_opcode  = op;
        cmd_barrier = bar;
        do begin
            acc = cmd_ready;
            next();
            budget--;
        end while (!acc && budget > 0);
        if (!acc) check("send_timeout", 32'(acc), 32'(1));
    endtask

    // Scoreboard: record accepted commands, compare each issued one in order.
    always @(negedge clk) begin : monitor
        cmd_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (issue) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_issue", 32'(issue), 32'(0));
                end else begin
                    e = sb.pop_front();
                    check("sb_cmd", 32'({ain, bin, opcode}), 32'({e.ain, e.bin, e.opcode}));
                end
            end
            if (cmd_valid && cmd_ready) begin
                sb.push_back('{ain: cmd_ain, bin: cmd_bin, opcode: cmd_opcode, barrier: cmd_barrier});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_ain = '0; cmd_bin = '0;
        cmd_opcode = '0; cmd_barrier = 1'b0; stall = 1'b0;
        repeat (3) next();

        // Reset state
        check("rst_cmd_ready", 32'(cmd_ready), 32'(0));
        check("rst_ain", 32'(ain), 32'(0));
        check("rst_bin", 32'(bin), 32'(0));
        check("rst_opcode", 32'(opcode), 32'(0));
        check("rst_issue", 32'(issue), 32'(0));
        check("rst_count", 32'(count), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        rst = 1'b0;
        next();

        // Basic latency: accept in cycle 0, issue in cycle 2
        check("t1_ready", 32'(cmd_ready), 32'(1));
        send(8'h12, 8'h34, 3'b010, 1'b0);
        cmd_valid = 1'b0;
        check("t1_c1_issue", 32'(issue), 32'(0));
        check("t1_c1_count", 32'(count), 32'(1));
        next();
        check("t1_c2_issue", 32'(issue), 32'(1));
        check("t1_c2_ain", 32'(ain), 32'h12);
        check("t1_c2_bin", 32'(bin), 32'h34);
        check("t1_c2_opcode", 32'(opcode), 32'(2));
        check("t1_c2_issue_z", 32'(issue_z), 32'(1));
        next();
        check("t1_c3_issue", 32'(issue), 32'(0));
        check("t1_c3_busy", 32'(busy), 32'(0));
        check("t1_c3_ain_hold", 32'(ain), 32'h12);
        next();

        // Full FIFO refuses the fifth command until a pop frees space
        stall = 1'b1;
        for (int i = 0; i < 4; i++) send(8'h20 + 8'(i), 8'h40 + 8'(i), 3'(i), 1'b0);
        cmd_ain = 8'h24; cmd_bin = 8'h44; cmd_opcode = 3'd4; cmd_barrier = 1'b0;
        check("t2_full_count", 32'(count), 32'(4));
        check("t2_full_ready", 32'(cmd_ready), 32'(0));
        next();
        check("t2_full_ready_hold", 32'(cmd_ready), 32'(0));
        stall = 1'b0;
        check("t2_ready_pop_cycle", 32'(cmd_ready), 32'(0));
        next();
        check("t2_k1_issue", 32'(issue), 32'(1));
        check("t2_k1_ready", 32'(cmd_ready), 32'(1));
        check("t2_k1_count", 32'(count), 32'(3));
        next();
        cmd_valid = 1'b0;
        check("t2_k2_issue", 32'(issue), 32'(1));
        check("t2_k2_count", 32'(count), 32'(3));
        for (int i = 0; i < 3; i++) begin
            next();
            check("t2_stream_issue", 32'(issue), 32'(1));
        end
        next();
        check("t2_end_issue", 32'(issue), 32'(0));
        check("t2_end_count", 32'(count), 32'(0));

        // Barrier: two drain cycles (DRAIN_CYCLES=2), none with DRAIN_CYCLES=0
        stall = 1'b1;
        send(8'hA1, 8'hB1, 3'd5, 1'b1);
        send(8'hA2, 8'hB2, 3'd6, 1'b0);
        cmd_valid = 1'b0;
        stall = 1'b0;
        next();
        check("t3_t_issue", 32'(issue), 32'(1));
        check("t3_t_ain", 32'(ain), 32'hA1);
        check("t3_t_issue_z", 32'(issue_z), 32'(1));
        check("t3_t_ain_z", 32'(ain_z), 32'hA1);
        next();
        check("t3_t1_issue", 32'(issue), 32'(0));
        check("t3_t1_busy", 32'(busy), 32'(1));
        check("t3_t1_issue_z", 32'(issue_z), 32'(1));
        check("t3_t1_ain_z", 32'(ain_z), 32'hA2);
        next();
        check("t3_t2_issue", 32'(issue), 32'(0));
        next();
        check("t3_t3_issue", 32'(issue), 32'(1));
        check("t3_t3_ain", 32'(ain), 32'hA2);
        check("t3_t3_opcode", 32'(opcode), 32'(6));
        next();
        check("t3_t4_issue", 32'(issue), 32'(0));

        // Single-cycle stall after first issue inserts exactly one gap
        stall = 1'b1;
        for (int i = 0; i < 3; i++) send(8'h60 + 8'(i), 8'h70 + 8'(i), 3'(i + 1), 1'b0);
        cmd_valid = 1'b0;
        stall = 1'b0;
        next();
        check("t4_t_issue", 32'(issue), 32'(1));
        check("t4_t_ain", 32'(ain), 32'h60);
        stall = 1'b1;
        next();
        check("t4_gap_issue", 32'(issue), 32'(0));
        check("t4_gap_ain_hold", 32'(ain), 32'h60);
        check("t4_gap_bin_hold", 32'(bin), 32'h70);
        stall = 1'b0;
        next();
        check("t4_c1_ain", 32'(ain), 32'h61);
        check("t4_c1_issue", 32'(issue), 32'(1));
        next();
        check("t4_c2_ain", 32'(ain), 32'h62);
        check("t4_c2_issue", 32'(issue), 32'(1));
        next();
        check("t4_end_issue", 32'(issue), 32'(0));

        // Streaming push+pop at occupancy 2 across pointer wrap
        stall = 1'b1;
        send(8'h80, 8'h90, 3'd0, 1'b0);
        send(8'h81, 8'h91, 3'd1, 1'b0);
        stall = 1'b0;
        for (int i = 2; i < 10; i++) begin
            cmd_valid = 1'b1; cmd_ain = 8'h80 + 8'(i); cmd_bin = 8'h90 + 8'(i);
            cmd_opcode = 3'(i); cmd_barrier = 1'b0;
            check("t5_count", 32'(count), 32'(2));
            check("t5_ready", 32'(cmd_ready), 32'(1));
            if (i > 2) check("t5_issue", 32'(issue), 32'(1));
            next();
        end
        cmd_valid = 1'b0;
        check("t5_after_count", 32'(count), 32'(2));
        repeat (3) next();
        check("t5_end_issue", 32'(issue), 32'(0));
        check("t5_end_count", 32'(count), 32'(0));

        // Reset asserted while draining with three commands queued
        stall = 1'b1;
        send(8'hE0, 8'hF0, 3'd7, 1'b1);
        for (int i = 1; i < 4; i++) send(8'hE0 + 8'(i), 8'hF0 + 8'(i), 3'(i), 1'b0);
        cmd_valid = 1'b0;
        stall = 1'b0;
        next();
        check("t6_issue_e0", 32'(issue), 32'(1));
        check("t6_count_drain", 32'(count), 32'(3));
        #2 rst = 1'b1;
        #1;
        check("t6_rst_ain", 32'(ain), 32'(0));
        check("t6_rst_bin", 32'(bin), 32'(0));
        check("t6_rst_opcode", 32'(opcode), 32'(0));
        check("t6_rst_issue", 32'(issue), 32'(0));
        check("t6_rst_count", 32'(count), 32'(0));
        check("t6_rst_ready", 32'(cmd_ready), 32'(0));
        next();
        next();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next();
            check("t6_idle_issue", 32'(issue), 32'(0));
            check("t6_idle_count", 32'(count), 32'(0));
        end
        send(8'h5A, 8'hA5, 3'd3, 1'b0);
        cmd_valid = 1'b0;
        check("t6_new_c1_issue", 32'(issue), 32'(0));
        next();
        check("t6_new_c2_issue", 32'(issue), 32'(1));
        check("t6_new_c2_ain", 32'(ain), 32'h5A);
        next();
        next();

        check("sb_empty", 32'(sb.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
